// File: rtl/bcd_convert_sched.sv
// bcd_convert_sched: serial double-dabble binary-to-BCD engine shared by two
// requesters through a round-robin scheduler. One add-3/shift step per clock.
// Optional build macro BCD_LEAD_BLANK_EN: when defined, leading zero digits of
// a finished result are shown as 4'hF (blank) on out_bcd.
//
// Handshakes: a request is taken on the rising edge where req_valid[i] and
// req_ready[i] are both high; req_ready is only ever high in IDLE and is
// one-hot. A result is consumed on the rising edge where out_valid and
// out_ready are both high; out_valid, out_bcd and out_src hold until then.
// FSM state is visible as r_state (type state_t) for checkers to bind to.
module bcd_convert_sched #(
   parameter int DATA_W = 32,
   parameter int DIGITS = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            req_valid,
   input  logic [DATA_W-1:0]     req_bin0,
   input  logic [DATA_W-1:0]     req_bin1,
   output logic [1:0]            req_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   out_bcd,
   output logic                  out_src,
   output logic                  busy
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CW-1:0]     r_cnt;
   logic [DATA_W-1:0] r_bin;
   logic [BW-1:0]     r_bcd;
   logic              r_src;
   logic              r_ptr;      // requester granted most recently
   logic              w_gnt_any;
   logic              w_gnt_idx;
   logic [BW-1:0]     w_bcd_adj;

   // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
   always_comb begin
      w_gnt_any = 1'b0;
      w_gnt_idx = 1'b0;
      if (r_state == S_IDLE) begin
         case (req_valid)
            2'b01: begin w_gnt_any = 1'b1; w_gnt_idx = 1'b0;   end
            2'b10: begin w_gnt_any = 1'b1; w_gnt_idx = 1'b1;   end
            2'b11: begin w_gnt_any = 1'b1; w_gnt_idx = ~r_ptr; end
            default: ;
         endcase
      end
   end

   assign req_ready = w_gnt_any ? (w_gnt_idx ? 2'b10 : 2'b01) : 2'b00;

   // Add-3 correction on every digit >= 5 before the shift.
   always_comb begin
      w_bcd_adj = r_bcd;
      for (int d = 0; d < DIGITS; d++) begin
         if (r_bcd[4*d +: 4] >= 4'd5) begin
            w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
         end
      end
   end

   // Next-state: IDLE -> SHIFT on grant, SHIFT -> DONE after the counter==0 step,
   // DONE -> IDLE on output handshake.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_gnt_any)     w_state_nxt = S_SHIFT;
         S_SHIFT: if (r_cnt == '0)   w_state_nxt = S_DONE;
         S_DONE:  if (out_ready)     w_state_nxt = S_IDLE;
         default:                    w_state_nxt = S_IDLE;
      endcase
   end

   // State register; reset aborts any conversion in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Datapath: operand capture on grant, one add-3/shift step per SHIFT cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_bin <= '0;
         r_bcd <= '0;
         r_src <= 1'b0;
         r_ptr <= 1'b1;   // so requester 0 wins the first tie
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_gnt_any) begin
                  r_bin <= w_gnt_idx ? req_bin1 : req_bin0;
                  r_bcd <= '0;
                  r_cnt <= CW'(DATA_W - 1);
                  r_src <= w_gnt_idx;
                  r_ptr <= w_gnt_idx;
               end
            end
            S_SHIFT: begin
               r_bcd <= {w_bcd_adj[BW-2:0], r_bin[DATA_W-1]};
               r_bin <= {r_bin[DATA_W-2:0], 1'b0};
               if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state != S_IDLE);
   assign out_src   = r_src;

`ifdef BCD_LEAD_BLANK_EN
   logic          r_blank_on;
   logic [BW-1:0] w_bcd_blank;
   logic          w_lead;

   // Blanking applies from the finished result until the next grant clears the accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                     r_blank_on <= 1'b0;
      else if ((r_state == S_SHIFT) && (r_cnt == '0)) r_blank_on <= 1'b1;
      else if (w_gnt_any)                             r_blank_on <= 1'b0;
   end

   // Replace zero digits above the most significant non-zero digit; digit 0 always shows.
   always_comb begin
      w_bcd_blank = r_bcd;
      w_lead      = 1'b1;
      for (int d = DIGITS - 1; d > 0; d--) begin
         if (w_lead && (r_bcd[4*d +: 4] == 4'd0)) w_bcd_blank[4*d +: 4] = 4'hF;
         else                                     w_lead = 1'b0;
      end
   end

   assign out_bcd = r_blank_on ? w_bcd_blank : r_bcd;
`else
   assign out_bcd = r_bcd;
`endif

endmodule

// File: tb/tb_bcd_convert_sched.sv
// Bench for bcd_convert_sched: directed vectors, expected results queued on issue,
// a negedge monitor pops and compares on every output handshake.
module tb_bcd_convert_sched;

   localparam int DATA_W  = 32;
   localparam int DIGITS  = 10;
   localparam int BW      = 40;
   localparam int LAT     = 33;   // accept edge through out_valid rising edge, inclusive
   localparam int SPACING = 34;   // grant-to-grant with out_ready high

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [1:0]        req_valid = 2'b00;
   logic [DATA_W-1:0] req_bin0 = '0;
   logic [DATA_W-1:0] req_bin1 = '0;
   logic [1:0]        req_ready;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [BW-1:0]     out_bcd;
   logic              out_src;
   logic              busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [BW:0] exp_q[$];     // {src, bcd}
   int          gnt_idx_q[$];
   int          gnt_cyc_q[$];
   int          rise_cyc = 0;
   int          hs_cyc   = 0;
   logic        prev_ready = 1'b0;
   logic        prev_valid = 1'b0;

   bcd_convert_sched #(.DATA_W(DATA_W), .DIGITS(DIGITS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_bin0  (req_bin0),
      .req_bin1  (req_bin1),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bcd   (out_bcd),
      .out_src   (out_src),
      .busy      (busy)
   );

   // ---------------- clock / cycle count / watchdog ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- helpers ----------------
   function automatic logic [BW-1:0] fmt(input logic [BW-1:0] b);
      logic [BW-1:0] r;
      r = b;
`ifdef BCD_LEAD_BLANK_EN
      for (int d = DIGITS - 1; d > 0; d--) begin
         if (b[4*d +: 4] != 4'd0) break;
         r[4*d +: 4] = 4'hF;
      end
`endif
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin : monitor
      logic [BW:0] e;
      if (rst_n) begin
         if (req_ready != 2'b00) begin
            check("grant_onehot_single_cycle",
                  {63'd0, ($onehot(req_ready) && ((req_ready & ~req_valid) == 2'b00) && !prev_ready)},
                  64'd1);
            gnt_idx_q.push_back(req_ready[1] ? 1 : 0);
            gnt_cyc_q.push_back(cyc + 1);
         end
         if (out_valid && !prev_valid) rise_cyc = cyc;
         if (out_valid && out_ready) begin
            hs_cyc = cyc + 1;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_result actual=%0h required=none", out_bcd);
            end else begin
               e = exp_q.pop_front();
               check("result_bcd", {24'd0, out_bcd}, {24'd0, e[BW-1:0]});
               check("result_src", {63'd0, out_src}, {63'd0, e[BW]});
            end
         end
      end
      prev_ready = (req_ready != 2'b00);
      prev_valid = out_valid;
   end

   // ---------------- driver tasks ----------------
   task automatic wait_grant(input int idx, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (req_ready[idx]) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL grant_timeout req=%0d actual=none required=grant", idx);
      end
   endtask

   task automatic issue(input int idx, input logic [DATA_W-1:0] val, input logic [BW-1:0] exp);
      bit ok;
      exp_q.push_back({idx[0], fmt(exp)});
      @(posedge clk); #1;
      if (idx == 0) req_bin0 = val;
      else          req_bin1 = val;
      req_valid[idx] = 1'b1;
      wait_grant(idx, ok);
      @(posedge clk); #1;
      req_valid[idx] = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0) break;
      end
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
         exp_q.delete();
      end
      @(posedge clk); #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin : stim
      bit ok;
      int n0;
      int acc;

      // reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_out_bcd",   {24'd0, out_bcd},   64'd0);
      check("rst_out_src",   {63'd0, out_src},   64'd0);
      check("rst_busy",      {63'd0, busy},      64'd0);
      check("rst_req_ready", {62'd0, req_ready}, 64'd0);
      @(posedge clk); #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;

      // T1: single request, latency
      issue(0, 32'd1234, 40'h0000001234);
      drain();
      check("t1_grant_idx", gnt_idx_q[gnt_idx_q.size()-1], 0);
      check("t1_latency", rise_cyc - gnt_cyc_q[gnt_cyc_q.size()-1] + 1, LAT);

      // T2: maximum value then zero on requester 1
      issue(1, 32'hFFFF_FFFF, 40'h4294967295);
      issue(1, 32'd0, 40'h0000000000);
      drain();
      check("t2_grant_idx", gnt_idx_q[gnt_idx_q.size()-1], 1);

      // T3: both requesters held valid, grants alternate
      n0 = gnt_cyc_q.size();
      exp_q.push_back({1'b0, fmt(40'h7)});
      exp_q.push_back({1'b1, fmt(40'h9)});
      exp_q.push_back({1'b0, fmt(40'h7)});
      exp_q.push_back({1'b1, fmt(40'h9)});
      @(posedge clk); #1;
      req_bin0  = 32'd7;
      req_bin1  = 32'd9;
      req_valid = 2'b11;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk); #1;
         if (gnt_cyc_q.size() >= n0 + 4) break;
      end
      @(posedge clk); #1;
      req_valid = 2'b00;
      drain();
      if (gnt_cyc_q.size() >= n0 + 4) begin
         for (int k = 0; k < 4; k++) check("t3_grant_order", gnt_idx_q[n0+k], k % 2);
         for (int k = 1; k < 4; k++) check("t3_grant_spacing", gnt_cyc_q[n0+k] - gnt_cyc_q[n0+k-1], SPACING);
      end else begin
         checks++;
         failures++;
         $display("FAIL t3_grant_count actual=%0d required=4", gnt_cyc_q.size() - n0);
      end

      // T4: back-pressure with a pending request
      out_ready = 1'b0;
      issue(0, 32'd42, 40'h42);
      req_bin1 = 32'd55;
      req_valid[1] = 1'b1;
      exp_q.push_back({1'b1, fmt(40'h55)});
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (out_valid) begin ok = 1'b1; break; end
      end
      check("t4_valid_seen", {63'd0, ok}, 64'd1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("t4_hold_valid", {63'd0, out_valid}, 64'd1);
         check("t4_hold_bcd",   {24'd0, out_bcd},   {24'd0, fmt(40'h42)});
         check("t4_hold_src",   {63'd0, out_src},   64'd0);
         check("t4_no_grant",   {62'd0, req_ready}, 64'd0);
         check("t4_busy",       {63'd0, busy},      64'd1);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_grant(1, ok);
      @(posedge clk); #1;
      req_valid = 2'b00;
      check("t4_grant_after_hs", gnt_cyc_q[gnt_cyc_q.size()-1] - hs_cyc, 1);
      drain();

      // T5: asynchronous reset at shift step 15
      @(posedge clk); #1;
      req_bin1  = 32'hFFFF_FFFF;
      req_valid = 2'b10;
      wait_grant(1, ok);
      @(posedge clk); #1;
      req_valid = 2'b00;
      acc = gnt_cyc_q[gnt_cyc_q.size()-1];
      repeat (15) @(posedge clk);
      #3;
      check("t5_at_step15", cyc - acc, 15);
      rst_n = 1'b0;
      #1;
      check("t5_rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("t5_rst_busy",      {63'd0, busy},      64'd0);
      check("t5_rst_out_bcd",   {24'd0, out_bcd},   64'd0);
      check("t5_rst_out_src",   {63'd0, out_src},   64'd0);
      check("t5_rst_req_ready", {62'd0, req_ready}, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      issue(1, 32'd305, 40'h305);

      // T6: request withdrawn before acceptance is never granted
      req_bin0 = 32'd77;
      req_valid[0] = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      req_valid[0] = 1'b0;
      n0 = gnt_cyc_q.size();
      drain();
      repeat (3) @(posedge clk);
      #1;
      check("t6_withdrawn_no_grant", gnt_cyc_q.size() - n0, 0);

      // T7: first tie after reset goes to requester 0
      n0 = gnt_idx_q.size();
      exp_q.push_back({1'b0, fmt(40'h8)});
      exp_q.push_back({1'b1, fmt(40'h6)});
      req_bin0  = 32'd8;
      req_bin1  = 32'd6;
      req_valid = 2'b11;
      wait_grant(0, ok);
      @(posedge clk); #1;
      req_valid = 2'b10;
      wait_grant(1, ok);
      @(posedge clk); #1;
      req_valid = 2'b00;
      drain();
      if (gnt_idx_q.size() > n0) check("t7_first_tie_idx", gnt_idx_q[n0], 0);
      else begin
         checks++;
         failures++;
         $display("FAIL t7_grant_count actual=0 required=2");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
